prog_timer: RTL
===============

// Module: prog_timer
// PURPOSE
//  Parametrised programmable timer, successor to the single-mode timer.
//  Counts up to a programmable limit, or down to zero, from a loaded start value.
//  Adds a clock prescaler, one-shot/periodic modes, explicit load, and running/done status.
//  Sits beside control FSMs as a general delay, timeout or periodic-tick source.
// PARAMETERS
//  WIDTH       16  counter width in bits; start_value, limit and timer_value are all this width
//  PRESCALE_W   8  prescaler width; a tick occurs every (prescale+1) enabled cycles
// PORTS
//  clk          in   1           system clock, rising edge
//  reset        in   1           synchronous, active-high reset
//  enable       in   1           1 = prescaler and counter advance; 0 = freeze all state
//  up           in   1           1 = count up to limit; 0 = count down to 0
//  mode         in   1           0 = one-shot; 1 = periodic (auto-reload)
//  load         in   1           1-cycle strobe: load start_value and enter RUN
//  start_value  in   WIDTH       value loaded on load and on each periodic reload
//  limit        in   WIDTH       terminal value when up=1
//  prescale     in   PRESCALE_W  tick divider minus one
//  timer_value  out  WIDTH       current count, registered
//  max_reached  out  1           1-cycle pulse on each expiry, registered
//  running      out  1           1 while state==RUN
//  done         out  1           1 while state==DONE (one-shot expired)
// BEHAVIOUR
//  States: IDLE, RUN, DONE.
//  Reset:
//   - forces IDLE; timer_value=0, max_reached=0, running=0, done=0, prescaler count=0.
//   - Has priority over every other input, including in the same cycle as load.
//  load=1 (any state, regardless of enable):
//   - timer_value<=start_value, prescaler<=0, state<=RUN.
//   - max_reached<=0 in that cycle.
//  IDLE/DONE:
//   - timer_value holds; only load or reset leave the state.
//  RUN with enable=0:
//   - prescaler and timer_value hold; max_reached=0.
//  RUN with enable=1:
//   - The prescaler increments each cycle.
//   - When prescaler==prescale, it clears and a tick occurs that cycle.
//   - prescale=0 gives a tick every enabled cycle.
//  terminal = up ? limit : 0, re-evaluated every cycle (up/limit may change mid-run).
//  On a tick:
//   - If timer_value!=terminal: step by +1 (up) or -1 (down), modulo 2^WIDTH.
//   - If timer_value==terminal: expiry. max_reached=1 for exactly the next cycle.
//  Expiry outcome by mode:
//   - periodic: timer_value<=start_value; stay RUN.
//   - one-shot: timer_value holds terminal; state<=DONE.
//  Period: periodic mode expires every (|terminal-start_value|+1)*(prescale+1) enabled cycles.
//  Boundary conditions:
//   - start_value==terminal: expires on the first tick.
//   - up=1 with start_value>limit: wraps through 2^WIDTH-1 -> 0 before reaching limit.
//   - Down mode with start_value=0: expires on the first tick.
//   - load on the same cycle as an expiry tick: load wins, no max_reached pulse.
//   - mode change mid-run: takes effect at the next expiry.
//   - Reset mid-count: all outputs return to reset values on the next edge.
//  running and done are decoded from registered state, so they are glitch-free.
// TESTING
//  1. reset=1 two cycles -> timer_value=0, max_reached=0, running=0, done=0.
//  2. up=1, mode=1, start=0, limit=3, prescale=0, load -> timer_value 0,1,2,3,0,1...;
//     max_reached pulses every 4th cycle, coincident with value 0.
//  3. up=0, mode=0, start=5, prescale=2, load -> value decrements every 3 cycles;
//     after 18 cycles max_reached pulses once, done=1, value holds 0.
//  4. Periodic count up; drop enable for 5 cycles mid-count -> value and prescaler frozen;
//     resume -> expiry delayed exactly 5 cycles.
//  5. up=1, WIDTH=16, start=16'hFFFE, limit=1 -> sequence FFFE, FFFF, 0000, 0001, then expiry.
//  6. Assert load and reset together -> reset state.
//     Assert load on the expiry cycle -> reloads, no max_reached pulse.
//     Reset mid-RUN -> IDLE next cycle.

Source files
------------

// File: rtl/prog_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_timer                                                   |
// | Description : Programmable up/down timer with prescaler, one-shot or       |
// |               periodic reload, explicit load and running/done status.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_timer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      start_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      timer_value,
    output logic                  max_reached,
    output logic                  running,
    output logic                  done
);

    localparam logic [1:0]            c_st_idle = 2'd0;
    localparam logic [1:0]            c_st_run  = 2'd1;
    localparam logic [1:0]            c_st_done = 2'd2;
    localparam logic [WIDTH-1:0]      c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] c_p_one   = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      r_count;
    logic [WIDTH-1:0]      w_count_nxt;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic                  r_max;
    logic                  w_max_nxt;

    logic [WIDTH-1:0]      w_terminal;
    logic                  w_active;
    logic                  w_tick;

    // Terminal is re-evaluated every cycle so up/limit may change mid-run.
    assign w_terminal = up ? limit : '0;
    assign w_active   = (r_state == c_st_run) && enable;
    assign w_tick     = w_active && (r_presc == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_count <= '0;
            r_presc <= '0;
            r_max   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_max   <= w_max_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_max_nxt   = 1'b0;
        if (load) begin
            w_state_nxt = c_st_run;
            w_count_nxt = start_value;
            w_presc_nxt = '0;
        end else if (w_active) begin
            w_presc_nxt = w_tick ? '0 : r_presc + c_p_one;
            if (w_tick) begin
                if (r_count == w_terminal) begin
                    w_max_nxt = 1'b1;
                    // One-shot parks on the terminal value; periodic reloads.
                    if (mode) begin
                        w_count_nxt = start_value;
                    end else begin
                        w_state_nxt = c_st_done;
                    end
                end else begin
                    w_count_nxt = up ? r_count + c_one : r_count - c_one;
                end
            end
        end
    end

    assign timer_value = r_count;
    assign max_reached = r_max;
    assign running     = (r_state == c_st_run);
    assign done        = (r_state == c_st_done);

endmodule
`default_nettype wire
